// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//
// Write-side initiator for the 8x16 register file. Results from the memory
// (load) and ALU producers are accepted via valid/ready. They are buffered in
// a small in-order FIFO and drained one per granted cycle onto the
// register-file write port. A pending-write bitmap and two forwarding lookups
// let decode stall or bypass on registers that still have queued writes.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, a result arriving while the queue is empty
//                  and the write port is granted is written straight through
//                  in the same cycle instead of being enqueued.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   mem_valid/ready/dest/data   load result producer (higher priority)
//   alu_valid/ready/dest/data   ALU result producer
//   wr_grant            write port available this cycle
//   reg_write_en/dest/data      register-file write port
//   chk_addr1/2, chk_hit1/2, chk_data1/2   forwarding lookups
//   pending             bit r set when a queued entry targets register r
//   count, full, empty  queue occupancy
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     wr_grant,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  input  logic [ADDR_W-1:0]        chk_addr1,
  output logic                     chk_hit1,
  output logic [DATA_W-1:0]        chk_data1,
  input  logic [ADDR_W-1:0]        chk_addr2,
  output logic                     chk_hit2,
  output logic [DATA_W-1:0]        chk_data2,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic              in_accept;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  idx;

  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // full is registered, so a pop in this cycle never frees room for an
  // enqueue in the same cycle. Memory wins ties because loads are older.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign in_accept = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign in_dest   = mem_valid ? mem_dest : alu_dest;
  assign in_data   = mem_valid ? mem_data : alu_data;

`ifdef WB_BYPASS_EN
  assign bypass = empty && wr_grant && in_accept && (in_dest != '0);
`else
  assign bypass = 1'b0;
`endif

  // Writes to register 0 are acknowledged but dropped.
  assign push = in_accept && (in_dest != '0) && !bypass;
  assign pop  = !empty && wr_grant;

  // Write port is driven from the head entry. The strobe is suppressed while
  // reset is asserted so nothing reaches the register file on that cycle.
  always_comb begin
    reg_write_en   = !empty && rst_n;
    reg_write_dest = empty ? '0 : dest_q[head];
    reg_write_data = empty ? '0 : data_q[head];
    if (bypass) begin
      reg_write_en   = rst_n;
      reg_write_dest = in_dest;
      reg_write_data = in_data;
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        dest_q[tail] <= in_dest;
        data_q[tail] <= in_data;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk valid entries oldest to youngest; later matches overwrite earlier
  // ones so the lookup data ends up as the youngest pending write.
  always_comb begin
    pending   = '0;
    chk_hit1  = 1'b0;
    chk_data1 = '0;
    chk_hit2  = 1'b0;
    chk_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < cnt) begin
        pending[dest_q[idx]] = 1'b1;
        if ((chk_addr1 != '0) && (dest_q[idx] == chk_addr1)) begin
          chk_hit1  = 1'b1;
          chk_data1 = data_q[idx];
        end
        if ((chk_addr2 != '0) && (dest_q[idx] == chk_addr2)) begin
          chk_hit2  = 1'b1;
          chk_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
//
// Self-checking bench for reg_writeback_queue in its default build.
// A table of directed vectors carries hand-derived expectations, and a
// queue-based scoreboard holds every write the bench expects to see; it is
// consulted and updated every cycle (directed, reset and random phases).
module tb_reg_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        wr_grant;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [2:0]  chk_addr1;
  logic        chk_hit1;
  logic [15:0] chk_data1;
  logic [2:0]  chk_addr2;
  logic        chk_hit2;
  logic [15:0] chk_data2;
  logic [7:0]  pending;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
  } entry_t;

  entry_t sb[$];

  typedef struct {
    logic        mv;
    logic [2:0]  md;
    logic [15:0] mdat;
    logic        av;
    logic [2:0]  ad;
    logic [15:0] adat;
    logic        g;
    logic [2:0]  c1;
    logic [2:0]  c2;
    logic        e_mr;
    logic        e_ar;
    logic        e_we;
    logic [2:0]  e_wd;
    logic [15:0] e_wdat;
    logic [2:0]  e_cnt;
    logic [7:0]  e_pend;
    logic        e_h1;
    logic [15:0] e_d1;
    logic        e_h2;
  } vec_t;

  vec_t vecs[22];

  reg_writeback_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_dest       (mem_dest),
    .mem_data       (mem_data),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .wr_grant       (wr_grant),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .chk_addr1      (chk_addr1),
    .chk_hit1       (chk_hit1),
    .chk_data1      (chk_data1),
    .chk_addr2      (chk_addr2),
    .chk_hit2       (chk_hit2),
    .chk_data2      (chk_data2),
    .pending        (pending),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic mv, input logic [2:0] md,
                               input logic [15:0] mdat, input logic av, input logic [2:0] ad,
                               input logic [15:0] adat, input logic g,
                               input logic [2:0] c1, input logic [2:0] c2);
    rst_n     = r;
    mem_valid = mv;
    mem_dest  = md;
    mem_data  = mdat;
    alu_valid = av;
    alu_dest  = ad;
    alu_data  = adat;
    wr_grant  = g;
    chk_addr1 = c1;
    chk_addr2 = c2;
  endtask

  // Compare every output against the scoreboard, then advance the scoreboard
  // to the state expected after the coming rising edge.
  task automatic checkOutput(input string tag);
    int          sz;
    logic        e_full;
    logic        e_mr;
    logic        e_ar;
    logic        e_en;
    logic [2:0]  e_dest;
    logic [15:0] e_data;
    logic [7:0]  e_pend;
    logic        h1;
    logic        h2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        acc;
    entry_t      ne;
    sz     = sb.size();
    e_full = (sz == 4);
    e_mr   = !e_full;
    e_ar   = !e_full && !mem_valid;
    e_en   = (sz != 0) && rst_n;
    e_dest = (sz != 0) ? sb[0].dest : 3'd0;
    e_data = (sz != 0) ? sb[0].data : 16'h0000;
    e_pend = 8'h00;
    h1 = 1'b0; h2 = 1'b0; d1 = 16'h0000; d2 = 16'h0000;
    foreach (sb[j]) begin
      e_pend[sb[j].dest] = 1'b1;
      if (chk_addr1 != 3'd0 && sb[j].dest == chk_addr1) begin h1 = 1'b1; d1 = sb[j].data; end
      if (chk_addr2 != 3'd0 && sb[j].dest == chk_addr2) begin h2 = 1'b1; d2 = sb[j].data; end
    end
    compareField({tag, " mem_ready"}, 32'(mem_ready), 32'(e_mr));
    compareField({tag, " alu_ready"}, 32'(alu_ready), 32'(e_ar));
    compareField({tag, " write_port"}, 32'({reg_write_en, reg_write_dest, reg_write_data}),
                 32'({e_en, e_dest, e_data}));
    compareField({tag, " count_flags"}, 32'({count, full, empty}),
                 32'({3'(sz), e_full, (sz == 0)}));
    compareField({tag, " pending"}, 32'(pending), 32'(e_pend));
    compareField({tag, " lookup1"}, 32'({chk_hit1, chk_data1}), 32'({h1, d1}));
    compareField({tag, " lookup2"}, 32'({chk_hit2, chk_data2}), 32'({h2, d2}));
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (e_en && wr_grant) void'(sb.pop_front());
      acc = 1'b0;
      ne.dest = 3'd0;
      ne.data = 16'h0000;
      if (mem_valid && e_mr) begin
        acc = 1'b1; ne.dest = mem_dest; ne.data = mem_data;
      end else if (alu_valid && e_ar) begin
        acc = 1'b1; ne.dest = alu_dest; ne.data = alu_data;
      end
      if (acc && ne.dest != 3'd0) sb.push_back(ne);
    end
  endtask

  initial begin
    // Directed vectors: inputs, then expected outputs for that same cycle.
    vecs[0]  = '{1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 1'b1,3'd3,3'd0, 1'b1,1'b0,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[1]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd3,3'd0, 1'b1,1'b1,1'b1,3'd3,16'h1234,3'd1,8'h08,1'b1,16'h1234,1'b0};
    vecs[2]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd3,3'd0, 1'b1,1'b1,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[3]  = '{1'b1,3'd2,16'hAAAA, 1'b1,3'd5,16'h5555, 1'b1,3'd2,3'd0, 1'b1,1'b0,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[4]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd5,16'h5555, 1'b1,3'd2,3'd5, 1'b1,1'b1,1'b1,3'd2,16'hAAAA,3'd1,8'h04,1'b1,16'hAAAA,1'b0};
    vecs[5]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd2,3'd5, 1'b1,1'b1,1'b1,3'd5,16'h5555,3'd1,8'h20,1'b0,16'h0000,1'b1};
    vecs[6]  = '{1'b1,3'd1,16'h0011, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[7]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h0022, 1'b0,3'd0,3'd0, 1'b1,1'b1,1'b1,3'd1,16'h0011,3'd1,8'h02,1'b0,16'h0000,1'b0};
    vecs[8]  = '{1'b1,3'd3,16'h0033, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b1,1'b0,1'b1,3'd1,16'h0011,3'd2,8'h06,1'b0,16'h0000,1'b0};
    vecs[9]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h0044, 1'b0,3'd0,3'd0, 1'b1,1'b1,1'b1,3'd1,16'h0011,3'd3,8'h0E,1'b0,16'h0000,1'b0};
    vecs[10] = '{1'b1,3'd7,16'h0077, 1'b1,3'd6,16'h0066, 1'b0,3'd4,3'd0, 1'b0,1'b0,1'b1,3'd1,16'h0011,3'd4,8'h1E,1'b1,16'h0044,1'b0};
    vecs[11] = '{1'b1,3'd7,16'h0077, 1'b0,3'd0,16'h0000, 1'b1,3'd1,3'd0, 1'b0,1'b0,1'b1,3'd1,16'h0011,3'd4,8'h1E,1'b1,16'h0011,1'b0};
    vecs[12] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd0,3'd0, 1'b1,1'b1,1'b1,3'd2,16'h0022,3'd3,8'h1C,1'b0,16'h0000,1'b0};
    vecs[13] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd0,3'd0, 1'b1,1'b1,1'b1,3'd3,16'h0033,3'd2,8'h18,1'b0,16'h0000,1'b0};
    vecs[14] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd0,3'd0, 1'b1,1'b1,1'b1,3'd4,16'h0044,3'd1,8'h10,1'b0,16'h0000,1'b0};
    vecs[15] = '{1'b1,3'd6,16'h0001, 1'b0,3'd0,16'h0000, 1'b0,3'd6,3'd0, 1'b1,1'b0,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[16] = '{1'b0,3'd0,16'h0000, 1'b1,3'd6,16'h0002, 1'b0,3'd6,3'd0, 1'b1,1'b1,1'b1,3'd6,16'h0001,3'd1,8'h40,1'b1,16'h0001,1'b0};
    vecs[17] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd6,3'd0, 1'b1,1'b1,1'b1,3'd6,16'h0001,3'd2,8'h40,1'b1,16'h0002,1'b0};
    vecs[18] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd6,3'd0, 1'b1,1'b1,1'b1,3'd6,16'h0001,3'd2,8'h40,1'b1,16'h0002,1'b0};
    vecs[19] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd6,3'd0, 1'b1,1'b1,1'b1,3'd6,16'h0002,3'd1,8'h40,1'b1,16'h0002,1'b0};
    vecs[20] = '{1'b0,3'd0,16'h0000, 1'b1,3'd0,16'hFFFF, 1'b1,3'd0,3'd0, 1'b1,1'b1,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};
    vecs[21] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd0,3'd0, 1'b1,1'b1,1'b0,3'd0,16'h0000,3'd0,8'h00,1'b0,16'h0000,1'b0};

    // Reset and reset-state checks.
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd5);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd5);
    @(negedge clk);
    compareField("reset count", 32'(count), 32'd0);
    compareField("reset empty_full", 32'({empty, full}), 32'b10);
    compareField("reset write_port", 32'({reg_write_en, reg_write_dest, reg_write_data}), 32'd0);
    compareField("reset pending", 32'(pending), 32'd0);
    compareField("reset lookup", 32'({chk_hit1, chk_data1, chk_hit2, chk_data2}), 32'd0);
    checkOutput("reset");
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad,
                    vecs[i].adat, vecs[i].g, vecs[i].c1, vecs[i].c2);
      @(negedge clk);
      compareField($sformatf("vec%0d ready", i), 32'({mem_ready, alu_ready}),
                   32'({vecs[i].e_mr, vecs[i].e_ar}));
      compareField($sformatf("vec%0d write", i), 32'({reg_write_en, reg_write_dest, reg_write_data}),
                   32'({vecs[i].e_we, vecs[i].e_wd, vecs[i].e_wdat}));
      compareField($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      compareField($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].e_pend));
      compareField($sformatf("vec%0d lookup", i), 32'({chk_hit1, chk_data1, chk_hit2}),
                   32'({vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2}));
      checkOutput($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // Reset with three queued writes discards them all.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 3'd3);
      @(negedge clk);
      checkOutput($sformatf("fill%0d", i));
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd3);
    @(negedge clk);
    compareField("rst_cycle count", 32'(count), 32'd3);
    compareField("rst_cycle wen", 32'(reg_write_en), 32'd0);
    checkOutput("rst_cycle");
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd3);
      @(negedge clk);
      compareField($sformatf("post_rst%0d state", i),
                   32'({reg_write_en, count, pending, chk_hit1, chk_hit2}), 32'd0);
      checkOutput($sformatf("post_rst%0d", i));
      @(posedge clk);
      #1;
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 2) != 0),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      @(negedge clk);
      checkOutput($sformatf("rand%0d", i));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the 8x16 register file; sits between the execute/memory stages and the register-file write port (reg_write_en / reg_write_dest / reg_write_data).
- Accepts results from two producers (ALU, memory load) via valid/ready.
- Buffers them in a small in-order FIFO and drains them one per granted cycle onto the write port.
- Exposes a pending-write bitmap and a forwarding lookup so decode can stall or bypass.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- DATA_W, 16, result data width
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- wr_grant  in  1  register-file write port available this cycle
- reg_write_en  out  1  write strobe to register file
- reg_write_dest  out  ADDR_W  write address
- reg_write_data  out  DATA_W  write data
- chk_addr1  in  ADDR_W  forwarding lookup address 1
- chk_hit1  out  1  a pending write to chk_addr1 exists
- chk_data1  out  DATA_W  data of youngest pending write to chk_addr1
- chk_addr2  in  ADDR_W  forwarding lookup address 2
- chk_hit2  out  1  as chk_hit1 for chk_addr2
- chk_data2  out  DATA_W  as chk_data1 for chk_addr2
- pending  out  2**ADDR_W  bit r set if any queued entry targets register r
- count  out  clog2(DEPTH)+1  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
Clock and reset:
- Single clock clk; reset rst_n is synchronous, active-low.
- Reset clears all entries, head/tail pointers and count to 0.
- Reset values: reg_write_en=0, reg_write_dest=0, reg_write_data=0, pending=0, chk_hit*=0, chk_data*=0, count=0, empty=1, full=0.
- Reset asserted mid-operation discards all queued writes; no write strobe is issued on the reset cycle.

Producer handshake:
- mem_ready = !full.
- alu_ready = !full && !mem_valid. Memory has priority because loads are older.
- At most one enqueue per cycle.
- full is the registered value. A dequeue in the same cycle does not open a slot for that cycle's enqueue.
- Register 0 (dest == 0) results are accepted (ready obeyed) but not stored; count is unchanged.

Drain:
- reg_write_en = !empty. dest/data are the head entry, driven from registered state.
- An entry is popped at the edge where reg_write_en && wr_grant.
- When wr_grant=0, the head is held stable with reg_write_en still high. The register file ignores the strobe only in the sense that the arbiter does not route it.
- reg_write_dest and reg_write_data are 0 whenever empty.

Latency and count:
- A result accepted at edge N appears on the write port in the cycle after N (earliest pop at edge N+1).
- Simultaneous enqueue and pop: count unchanged, and ordering is preserved.
- Pointers wrap modulo DEPTH.

Lookup:
- pending is computed combinationally from valid entries.
- chk_hitX = (chk_addrX != 0) && any valid entry has dest == chk_addrX.
- chk_dataX = data of the youngest (closest to tail) matching entry, else 0.
- The entry being popped this cycle still counts as pending.

Optional Feature:
WB_BYPASS_EN
- Defined: when the queue is empty, wr_grant=1 and an accepted non-zero-dest result arrives, it drives reg_write_en/dest/data combinationally in the same cycle and is not enqueued (zero latency). chk/pending are unaffected by bypassed items.
- Undefined: every accepted result passes through the queue (latency per Behaviour).

Test Plan:
- Reset, then mem_valid=1 dest=3 data=0x1234, wr_grant=1 -> mem_ready=1; next cycle reg_write_en=1 dest=3 data=0x1234, pending[3]=1; following cycle empty=1, pending=0.
- mem_valid and alu_valid both high (mem dest=2 data=0xAAAA, alu dest=5 data=0x5555) -> alu_ready=0, mem entry queued first. Next cycle alu accepted. Write port shows dest 2, then dest 5.
- wr_grant=0, enqueue 4 results (dests 1,2,3,4) -> full=1, mem_ready=alu_ready=0, count=4, pending=0x1E. Then wr_grant=1 -> writes 1,2,3,4 in order over 4 cycles.
- Enqueue dest=6 data=0x0001 then dest=6 data=0x0002 with wr_grant=0; chk_addr1=6 -> chk_hit1=1, chk_data1=0x0002. chk_addr2=0 -> chk_hit2=0.
- alu_valid dest=0 data=0xFFFF -> alu_ready=1, count stays 0, reg_write_en stays 0.
- Queue holding 3 entries, rst_n=0 for one cycle -> count=0, reg_write_en=0, pending=0; no queued write appears after reset.
